// File: rtl/idex_skid_stage.sv
// ============================================================================
// Module  : idex_skid_stage
// Brief   : ID/EX pipeline register with a two-entry skid buffer and
//           load-use bubble insertion.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module idex_skid_stage #(
  parameter int XLEN      = 32,
  parameter int CTRL_W    = 12,
  parameter int HAZARD_EN = 1
) (
  input  logic              CLK,
  input  logic              RSTB,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_value,
  input  logic [XLEN-1:0]   id_rs2_value,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_memread,
  input  logic              id_regwrite,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_value,
  output logic [XLEN-1:0]   ex_rs2_value,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_memread,
  output logic              ex_regwrite,
  output logic [15:0]       bubble_cnt
);

  localparam int PW          = 4*XLEN + 15 + CTRL_W + 2;
  localparam int RD_LSB      = CTRL_W + 2;
  localparam bit C_HAZARD_EN = (HAZARD_EN != 0);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   main_q, main_d;
  logic [PW-1:0]   skid_q, skid_d;
  logic [15:0]     bubble_q, bubble_d;
  logic [PW-1:0]   w_id_pack;
  logic [4:0]      w_main_rd;
  logic            w_hazard;
  logic            w_accept;

  // Payload layout: {pc, rs1v, rs2v, imm, rs1, rs2, rd, ctrl, memread, regwrite}
  assign w_id_pack = {id_pc, id_rs1_value, id_rs2_value, id_imm,
                      id_rs1, id_rs2, id_rd, id_ctrl, id_memread, id_regwrite};
  assign {ex_pc, ex_rs1_value, ex_rs2_value, ex_imm,
          ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_memread, ex_regwrite} = main_q;

  assign w_main_rd = main_q[RD_LSB +: 5];
  assign w_hazard  = C_HAZARD_EN && (state_q == ONE) && main_q[1] && main_q[0] &&
                     (w_main_rd != 5'd0) && id_valid &&
                     ((id_rs1 == w_main_rd) || (id_rs2 == w_main_rd));

  assign id_ready   = ~flush & (state_q != FULL) & ~w_hazard;
  assign w_accept   = id_valid & id_ready;
  assign ex_valid   = (state_q == ONE) || (state_q == FULL);
  assign bubble_cnt = bubble_q;

  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    bubble_d = bubble_q;

    if (w_hazard && !flush && (bubble_q != 16'hFFFF)) begin
      bubble_d = bubble_q + 16'd1;
    end

    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (w_accept) begin
            state_d = ONE;
            main_d  = w_id_pack;
          end
        end
        ONE: begin
          // A hazard drops id_ready, so a draining EX naturally yields the bubble.
          if (w_accept && ex_ready) begin
            main_d = w_id_pack;
          end else if (w_accept) begin
            state_d = FULL;
            skid_d  = w_id_pack;
          end else if (ex_ready) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (ex_ready) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q  <= EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      bubble_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      bubble_q <= bubble_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_idex_skid_stage.sv
// ============================================================================
// Module  : tb_idex_skid_stage
// Brief   : Bench for idex_skid_stage; two instances (HAZARD_EN=0/1) against a
//           two-deep FIFO reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_idex_skid_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] ctrl;
    logic        memread;
    logic        regwrite;
  } entry_t;

  logic   CLK;
  logic   RSTB;
  logic   flush;
  logic   id_valid;
  logic   ex_ready;
  entry_t in_e;

  logic        id_ready     [2];
  logic        ex_valid     [2];
  logic [31:0] ex_pc        [2];
  logic [31:0] ex_rs1_value [2];
  logic [31:0] ex_rs2_value [2];
  logic [31:0] ex_imm       [2];
  logic [4:0]  ex_rs1       [2];
  logic [4:0]  ex_rs2       [2];
  logic [4:0]  ex_rd        [2];
  logic [11:0] ex_ctrl      [2];
  logic        ex_memread   [2];
  logic        ex_regwrite  [2];
  logic [15:0] bubble_cnt   [2];

  // Reference model: ordered FIFO of up to two entries per instance.
  entry_t      mbuf  [2][2];
  int          msize [2];
  int unsigned mcnt  [2];

  int n_cmp = 0;
  int n_err = 0;

  generate
    for (genvar k = 0; k < 2; k++) begin : g_dut
      idex_skid_stage #(.XLEN(32), .CTRL_W(12), .HAZARD_EN(k)) u_dut (
        .CLK          (CLK),
        .RSTB         (RSTB),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_ready     (id_ready[k]),
        .id_pc        (in_e.pc),
        .id_rs1_value (in_e.rs1v),
        .id_rs2_value (in_e.rs2v),
        .id_imm       (in_e.imm),
        .id_rs1       (in_e.rs1),
        .id_rs2       (in_e.rs2),
        .id_rd        (in_e.rd),
        .id_ctrl      (in_e.ctrl),
        .id_memread   (in_e.memread),
        .id_regwrite  (in_e.regwrite),
        .ex_ready     (ex_ready),
        .ex_valid     (ex_valid[k]),
        .ex_pc        (ex_pc[k]),
        .ex_rs1_value (ex_rs1_value[k]),
        .ex_rs2_value (ex_rs2_value[k]),
        .ex_imm       (ex_imm[k]),
        .ex_rs1       (ex_rs1[k]),
        .ex_rs2       (ex_rs2[k]),
        .ex_rd        (ex_rd[k]),
        .ex_ctrl      (ex_ctrl[k]),
        .ex_memread   (ex_memread[k]),
        .ex_regwrite  (ex_regwrite[k]),
        .bubble_cnt   (bubble_cnt[k])
      );
    end
  endgenerate

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [199:0] payload(input int k);
    return {43'd0, ex_pc[k], ex_rs1_value[k], ex_rs2_value[k], ex_imm[k], ex_rs1[k],
            ex_rs2[k], ex_rd[k], ex_ctrl[k], ex_memread[k], ex_regwrite[k]};
  endfunction

  // Load-use: a single held load whose destination the ID instruction reads.
  function automatic bit m_hazard(input int k);
    entry_t m;
    m = mbuf[k][0];
    return (k == 1) && (msize[k] == 1) && m.memread && m.regwrite && (m.rd != 5'd0) &&
           id_valid && ((in_e.rs1 == m.rd) || (in_e.rs2 == m.rd));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      msize[k] = 0;
      mcnt[k]  = 0;
    end
  endtask

  // Caller sets inputs at posedge+1; checks id_ready, clocks, checks outputs.
  task automatic step();
    bit hz  [2];
    bit rdy [2];
    #1;
    for (int k = 0; k < 2; k++) begin
      hz[k]  = m_hazard(k);
      rdy[k] = !flush && (msize[k] < 2) && !hz[k];
      chk($sformatf("id_ready[%0d]", k), {199'd0, id_ready[k]}, {199'd0, rdy[k]});
    end
    @(posedge CLK);
    for (int k = 0; k < 2; k++) begin
      if (flush) begin
        msize[k] = 0;
      end else begin
        if (ex_ready && msize[k] > 0) begin
          mbuf[k][0] = mbuf[k][1];
          msize[k]--;
        end
        if (id_valid && rdy[k]) begin
          mbuf[k][msize[k]] = in_e;
          msize[k]++;
        end
      end
      if (hz[k] && !flush && mcnt[k] < 32'hFFFF) mcnt[k]++;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ex_valid[%0d]", k), {199'd0, ex_valid[k]}, {199'd0, msize[k] > 0});
      if (msize[k] > 0)
        chk($sformatf("ex_payload[%0d]", k), payload(k), {43'd0, mbuf[k][0]});
      chk($sformatf("bubble_cnt[%0d]", k), {184'd0, bubble_cnt[k]}, {184'd0, mcnt[k][15:0]});
    end
  endtask

  task automatic set_in(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic mr, input logic rw);
    in_e.pc       = pc;
    in_e.rs1v     = $urandom;
    in_e.rs2v     = $urandom;
    in_e.imm      = $urandom;
    in_e.rs1      = rs1;
    in_e.rs2      = rs2;
    in_e.rd       = rd;
    in_e.ctrl     = 12'($urandom);
    in_e.memread  = mr;
    in_e.regwrite = rw;
  endtask

  task automatic drive(input logic v, input logic er, input logic fl);
    id_valid = v;
    ex_ready = er;
    flush    = fl;
  endtask

  initial begin
    RSTB = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    in_e = '0;
    model_reset();
    #3;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_ex_valid[%0d]", k), {199'd0, ex_valid[k]}, 200'd0);
      chk($sformatf("rst_payload[%0d]", k), payload(k), 200'd0);
      chk($sformatf("rst_bubble[%0d]", k), {184'd0, bubble_cnt[k]}, 200'd0);
    end
    @(posedge CLK);
    #1;
    RSTB = 1'b1;

    // Streaming: back-to-back pcs with EX always ready.
    for (int i = 0; i < 3; i++) begin
      set_in(32'(4*i), 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 1'b1, 1'b0);
    step();

    // Backpressure: fill both entries, then drain in order.
    set_in(32'h10, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b0); step();
    set_in(32'h14, 5'd1, 5'd2, 5'd4, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b0); step();
    set_in(32'h18, 5'd1, 5'd2, 5'd4, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b0); step();
    drive(1'b0, 1'b1, 1'b0); step();
    step();
    step();

    // Load-use with rd=5, then the same pattern with rd=0.
    for (int r = 0; r < 2; r++) begin
      logic [4:0] rdv;
      rdv = (r == 0) ? 5'd5 : 5'd0;
      set_in(32'h100, 5'd1, 5'd2, rdv, 1'b1, 1'b1); drive(1'b1, 1'b1, 1'b0); step();
      set_in(32'h104, rdv, 5'd7, 5'd6, 1'b0, 1'b1); drive(1'b1, 1'b1, 1'b0); step();
      step();
      drive(1'b0, 1'b1, 1'b0); step();
      step();
    end

    // Flush while full, with a valid instruction on the flush cycle.
    set_in(32'h200, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b0); step();
    set_in(32'h204, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b0); step();
    set_in(32'h208, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1); drive(1'b1, 1'b1, 1'b1); step();
    drive(1'b0, 1'b0, 1'b0); step();

    // Randomized traffic; small register numbers make load-use frequent.
    for (int i = 0; i < 600; i++) begin
      set_in($urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 19) == 0));
      step();
    end

    // Asynchronous reset with a pending hazard and a full instance.
    drive(1'b0, 1'b1, 1'b0); step(); step();
    set_in(32'h300, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1); drive(1'b1, 1'b0, 1'b0); step();
    set_in(32'h304, 5'd5, 5'd2, 5'd6, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b0); step(); step();
    #2;
    RSTB = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("arst_ex_valid[%0d]", k), {199'd0, ex_valid[k]}, 200'd0);
      chk($sformatf("arst_ex_pc[%0d]", k), {168'd0, ex_pc[k]}, 200'd0);
      chk($sformatf("arst_bubble[%0d]", k), {184'd0, bubble_cnt[k]}, 200'd0);
    end
    model_reset();
    @(posedge CLK);
    #1;
    RSTB = 1'b1;
    drive(1'b0, 1'b1, 1'b0); step(); step();

    // Saturation: hold a load in main and keep a dependent instruction waiting.
    set_in(32'h400, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1); drive(1'b1, 1'b0, 1'b0); step();
    set_in(32'h404, 5'd5, 5'd2, 5'd6, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) step();
    chk("sat_bubble", {184'd0, bubble_cnt[1]}, {184'd0, 16'hFFFF});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/idex_skid_stage.md
IDEX_SKID_STAGE -- requirements
Module: idex_skid_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: data/address width.
REQ-002 SHALL have parameter CTRL_W, default 12: width of opaque control bundle (ALUControl, ALUSource, Dmem selects).
REQ-003 SHALL have parameter HAZARD_EN, default 1: 1 enables load-use bubble insertion, 0 disables.
REQ-004 SHALL have ports, in this order:
- CLK  in  1  the single clock; all state changes on rising edge.
- RSTB  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- id_valid  in  1  ID presents an instruction.
- id_ready  out  1  stage accepts this cycle.
- id_pc, id_rs1_value, id_rs2_value, id_imm  in  XLEN each  payload.
- id_rs1, id_rs2, id_rd  in  5 each  register addresses.
- id_ctrl  in  CTRL_W  control bundle.
- id_memread, id_regwrite  in  1 each  load flag, writeback flag.
- ex_ready  in  1  EX consumes this cycle.
- ex_valid  out  1  output entry valid.
- ex_pc, ex_rs1_value, ex_rs2_value, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_memread, ex_regwrite  out  widths as id_*  registered payload.
- bubble_cnt  out  16  saturating count of hazard-stall cycles.

Function
REQ-005 SHALL hold up to two entries: main (drives ex_*) and skid; states EMPTY, ONE, FULL.
REQ-006 SHALL define accept = id_valid & id_ready; transfer out = ex_valid & ex_ready.
REQ-007 SHALL drive ex_valid = 1 exactly when state is ONE or FULL; ex_* outputs come directly from main registers.
REQ-008 SHALL define hazard = HAZARD_EN & state==ONE & main.memread & main.regwrite & main.rd!=0 & id_valid & (id_rs1==main.rd | id_rs2==main.rd).
REQ-009 SHALL drive id_ready = ~flush & (state!=FULL) & ~hazard (combinational).
REQ-010 SHALL transition EMPTY: accept -> ONE, main<=id payload; else stay.
REQ-011 SHALL transition ONE: accept & ex_ready -> ONE, main<=id; accept & ~ex_ready -> FULL, skid<=id; ~accept & ex_ready -> EMPTY; else hold.
REQ-012 SHALL transition FULL: ex_ready -> ONE, main<=skid; else hold with both entries unchanged.
REQ-013 SHALL preserve order: no entry overtakes another; skid never loaded while FULL.
REQ-014 SHALL, on hazard with ex_ready=1, move to EMPTY (one-cycle bubble, ex_valid=0 next cycle); the held ID instruction is accepted on the following cycle.
REQ-015 SHALL, on hazard with ex_ready=0, hold main and keep id_ready=0 until main leaves.
REQ-016 SHALL, when flush=1, go to EMPTY next edge regardless of id_valid/ex_ready; payload registers may retain stale values.
REQ-017 SHALL increment bubble_cnt by 1 each cycle hazard=1 and flush=0, saturating at 16'hFFFF (no wrap).
REQ-018 SHALL leave payload registers unchanged whenever not loaded, so ex_* stay stable while ex_valid & ~ex_ready.
REQ-019 SHALL incur latency of exactly one cycle from accept into EMPTY/ONE-with-drain to ex_valid.

Reset
REQ-020 SHALL, while RSTB=0, asynchronously force state EMPTY, ex_valid=0, all ex_* payload outputs 0, bubble_cnt 0.
REQ-021 SHALL, after RSTB rises, present id_ready=1 in the first cycle (flush=0).
REQ-022 SHALL, on RSTB asserted mid-operation (FULL, hazard pending), discard both entries; no entry reappears after release.

Verification
REQ-023 Streaming: ex_ready=1, id_valid=1, pc 0x0,0x4,0x8 back-to-back -> ex_pc 0x0,0x4,0x8 on consecutive cycles, id_ready constantly 1.
REQ-024 Backpressure: load pc 0x10,0x14, ex_ready=0 two cycles -> FULL, id_ready=0, ex_pc holds 0x10; ex_ready=1 -> 0x10 then 0x14, no loss/duplication.
REQ-025 Load-use: main = load rd=5 memread=1, ID presents add rs1=5, ex_ready=1 -> id_ready=0 one cycle, ex_valid=0 one cycle, add appears next; bubble_cnt=1. Same with rd=0 or HAZARD_EN=0 -> no bubble.
REQ-026 Flush: state FULL, flush=1 with id_valid=1 -> next cycle ex_valid=0, id_ready=1, flushed-cycle instruction not captured.
REQ-027 Reset mid-run: RSTB=0 async between edges while FULL -> ex_valid=0 immediately, ex_pc=0, bubble_cnt=0.
REQ-028 Saturation: force 70000 hazard cycles -> bubble_cnt stops at 0xFFFF.
